// File: rtl/spi_reg_arbiter.sv
// Configuration register bank shared by two requesters (SPI decoder, sequencer)
// with arbitration, read-back, address checking and period-synchronous duty updates.
module spi_reg_arbiter #(
    parameter int unsigned NUM_REGS   = 5,
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned DATA_W     = 8,
    parameter bit          SYNC_DUTY  = 1'b1,
    parameter bit          PRIO_FIXED = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s0_valid,
    output logic              s0_ready,
    input  logic              s0_write,
    input  logic [ADDR_W-1:0] s0_addr,
    input  logic [DATA_W-1:0] s0_wdata,
    input  logic              s1_valid,
    output logic              s1_ready,
    input  logic              s1_write,
    input  logic [ADDR_W-1:0] s1_addr,
    input  logic [DATA_W-1:0] s1_wdata,
    output logic              rvalid,
    output logic              rid,
    output logic [DATA_W-1:0] rdata,
    output logic              addr_err,
    input  logic              pwm_period_end,
    output logic              duty_pending,
    output logic [DATA_W-1:0] en_reg_out_7_0,
    output logic [DATA_W-1:0] en_reg_out_15_8,
    output logic [DATA_W-1:0] en_reg_pwm_7_0,
    output logic [DATA_W-1:0] en_reg_pwm_15_8,
    output logic [DATA_W-1:0] pwm_duty_cycle
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_OUT_LO = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_OUT_HI = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_PWM_LO = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ADDR_PWM_HI = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] ADDR_DUTY   = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT  = ADDR_W'(NUM_REGS);

    state_t              r_state;
    logic                r_last_grant;
    logic                r_port;
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_rvalid;
    logic                r_rid;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_addr_err;
    logic                r_duty_pending;
    logic [DATA_W-1:0]   r_duty_shadow;
    logic [DATA_W-1:0]   r_out_lo;
    logic [DATA_W-1:0]   r_out_hi;
    logic [DATA_W-1:0]   r_pwm_lo;
    logic [DATA_W-1:0]   r_pwm_hi;
    logic [DATA_W-1:0]   r_duty;

    logic                w_winner;
    logic                w_any_valid;
    logic                w_legal;
    logic                w_exec_wr;
    logic                w_duty_wr;
    logic                w_sel_write;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic [DATA_W-1:0]   w_rd_data;

    // Tie-break: round-robin flips against the previous grant, fixed priority favours port 0.
    always_comb begin
        w_winner = 1'b0;
        if (s0_valid && s1_valid) begin
            w_winner = PRIO_FIXED ? 1'b0 : ~r_last_grant;
        end else if (s1_valid) begin
            w_winner = 1'b1;
        end
    end

    assign w_any_valid = s0_valid | s1_valid;
    assign s0_ready    = (r_state == ST_IDLE) && s0_valid && !w_winner;
    assign s1_ready    = (r_state == ST_IDLE) && s1_valid &&  w_winner;

    assign w_sel_write = w_winner ? s1_write : s0_write;
    assign w_sel_addr  = w_winner ? s1_addr  : s0_addr;
    assign w_sel_wdata = w_winner ? s1_wdata : s0_wdata;

    assign w_legal   = (r_addr < ADDR_LIMIT);
    assign w_exec_wr = (r_state == ST_EXEC) && r_write && w_legal;
    assign w_duty_wr = w_exec_wr && (r_addr == ADDR_DUTY);

    // With deferred duty updates, read-back reports the last written (shadow) value.
    always_comb begin
        w_rd_data = '0;
        if (w_legal) begin
            case (r_addr)
                ADDR_OUT_LO: w_rd_data = r_out_lo;
                ADDR_OUT_HI: w_rd_data = r_out_hi;
                ADDR_PWM_LO: w_rd_data = r_pwm_lo;
                ADDR_PWM_HI: w_rd_data = r_pwm_hi;
                ADDR_DUTY:   w_rd_data = SYNC_DUTY ? r_duty_shadow : r_duty;
                default:     w_rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_last_grant   <= 1'b1;
            r_port         <= 1'b0;
            r_write        <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_rvalid       <= 1'b0;
            r_rid          <= 1'b0;
            r_rdata        <= '0;
            r_addr_err     <= 1'b0;
            r_duty_pending <= 1'b0;
            r_duty_shadow  <= '0;
            r_out_lo       <= '0;
            r_out_hi       <= '0;
            r_pwm_lo       <= '0;
            r_pwm_hi       <= '0;
            r_duty         <= '0;
        end else begin
            r_rvalid   <= 1'b0;
            r_addr_err <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_any_valid) begin
                        r_port       <= w_winner;
                        r_last_grant <= w_winner;
                        r_write      <= w_sel_write;
                        r_addr       <= w_sel_addr;
                        r_wdata      <= w_sel_wdata;
                        r_state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_addr_err <= ~w_legal;
                    if (r_write) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_rdata  <= w_rd_data;
                        r_rvalid <= 1'b1;
                        r_rid    <= r_port;
                        r_state  <= ST_RESP;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase

            if (w_exec_wr) begin
                case (r_addr)
                    ADDR_OUT_LO: r_out_lo <= r_wdata;
                    ADDR_OUT_HI: r_out_hi <= r_wdata;
                    ADDR_PWM_LO: r_pwm_lo <= r_wdata;
                    ADDR_PWM_HI: r_pwm_hi <= r_wdata;
                    ADDR_DUTY: begin
                        if (!SYNC_DUTY) begin
                            r_duty <= r_wdata;
                        end
                    end
                    default: ;
                endcase
            end

            // A duty write landing on the period boundary is applied directly and clears any older pending value.
            if (SYNC_DUTY) begin
                if (w_duty_wr) begin
                    r_duty_shadow <= r_wdata;
                    if (pwm_period_end) begin
                        r_duty         <= r_wdata;
                        r_duty_pending <= 1'b0;
                    end else begin
                        r_duty_pending <= 1'b1;
                    end
                end else if (pwm_period_end && r_duty_pending) begin
                    r_duty         <= r_duty_shadow;
                    r_duty_pending <= 1'b0;
                end
            end
        end
    end

    assign rvalid          = r_rvalid;
    assign rid             = r_rid;
    assign rdata           = r_rdata;
    assign addr_err        = r_addr_err;
    assign duty_pending    = SYNC_DUTY ? r_duty_pending : 1'b0;
    assign en_reg_out_7_0  = r_out_lo;
    assign en_reg_out_15_8 = r_out_hi;
    assign en_reg_pwm_7_0  = r_pwm_lo;
    assign en_reg_pwm_15_8 = r_pwm_hi;
    assign pwm_duty_cycle  = r_duty;

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Self-checking bench for spi_reg_arbiter: vector table with read scoreboard,
// plus hand sequences for reset, arbitration and duty synchronisation.
module tb_spi_reg_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       s0_valid, s0_write, s1_valid, s1_write;
    logic [6:0] s0_addr, s1_addr;
    logic [7:0] s0_wdata, s1_wdata;
    logic       pwm_period_end;

    logic       s0_ready, s1_ready, rvalid, rid, addr_err, duty_pending;
    logic [7:0] rdata, en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

    logic       p_s0_ready, p_s1_ready, p_rvalid, p_rid, p_addr_err, p_duty_pending;
    logic [7:0] p_rdata, p_out_lo, p_out_hi, p_pwm_lo, p_pwm_hi, p_duty;

    always #5 clk = ~clk;

    spi_reg_arbiter dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_write(s0_write), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_write(s1_write), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
        .rvalid(rvalid), .rid(rid), .rdata(rdata), .addr_err(addr_err),
        .pwm_period_end(pwm_period_end), .duty_pending(duty_pending),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle)
    );

    spi_reg_arbiter #(.SYNC_DUTY(1'b0), .PRIO_FIXED(1'b1)) dut_p (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_ready(p_s0_ready), .s0_write(s0_write), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
        .s1_valid(s1_valid), .s1_ready(p_s1_ready), .s1_write(s1_write), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
        .rvalid(p_rvalid), .rid(p_rid), .rdata(p_rdata), .addr_err(p_addr_err),
        .pwm_period_end(pwm_period_end), .duty_pending(p_duty_pending),
        .en_reg_out_7_0(p_out_lo), .en_reg_out_15_8(p_out_hi),
        .en_reg_pwm_7_0(p_pwm_lo), .en_reg_pwm_15_8(p_pwm_hi),
        .pwm_duty_cycle(p_duty)
    );

    typedef struct {
        bit         port;
        bit         wr;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_data;
        bit         exp_err;
    } vec_t;

    typedef struct {
        bit         rid;
        logic [7:0] data;
    } rsp_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    rsp_t       sb[$];
    logic [7:0] mdl[5];
    vec_t       vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] dut_reg(input int a);
        case (a)
            0:       return en_reg_out_7_0;
            1:       return en_reg_out_15_8;
            2:       return en_reg_pwm_7_0;
            3:       return en_reg_pwm_15_8;
            default: return pwm_duty_cycle;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rvalid_unexpected: actual rvalid=1 required 0");
            end else begin
                rsp_t e;
                e = sb.pop_front();
                chk("rid", {31'd0, rid}, {31'd0, e.rid});
                chk("rdata", {24'd0, rdata}, {24'd0, e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_req(input bit port, input bit wr, input logic [6:0] addr,
                             input logic [7:0] data, input bit pwm);
        bit ok = 1'b0;
        @(posedge clk); #1;
        if (port) begin
            s1_valid = 1'b1; s1_write = wr; s1_addr = addr; s1_wdata = data;
        end else begin
            s0_valid = 1'b1; s0_write = wr; s0_addr = addr; s0_wdata = data;
        end
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (port ? s1_ready : s0_ready) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL handshake_timeout: actual ready=0 required 1 (port %0d)", port);
        end
        @(posedge clk); #1;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        pwm_period_end = pwm;
    endtask

    task automatic apply_vec(input vec_t v);
        bit legal = (v.addr < 7'd5);
        if (!v.wr) sb.push_back('{v.port, v.exp_data});
        drive_req(v.port, v.wr, v.addr, v.wdata, 1'b0);
        @(negedge clk);
        if (v.wr && legal) chk("write_not_early", {24'd0, dut_reg(int'(v.addr))}, {24'd0, mdl[v.addr]});
        @(posedge clk); #1;
        pwm_period_end = 1'b0;
        if (v.wr && legal) mdl[v.addr] = v.exp_data;
        @(negedge clk);
        chk("addr_err", {31'd0, addr_err}, {31'd0, v.exp_err});
        for (int a = 0; a < 5; a++) chk($sformatf("bank%0d", a), {24'd0, dut_reg(a)}, {24'd0, mdl[a]});
    endtask

    task automatic check_reset();
        for (int a = 0; a < 5; a++) chk($sformatf("rst_reg%0d", a), {24'd0, dut_reg(a)}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rid", {31'd0, rid}, 32'd0);
        chk("rst_rdata", {24'd0, rdata}, 32'd0);
        chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
        chk("rst_pending", {31'd0, duty_pending}, 32'd0);
        chk("rst_p_duty", {24'd0, p_duty}, 32'd0);
    endtask

    task automatic reset_both();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int a = 0; a < 5; a++) mdl[a] = 8'h00;
        @(negedge clk);
    endtask

    task automatic pulse_pwm();
        @(posedge clk); #1 pwm_period_end = 1'b1;
        @(posedge clk); #1 pwm_period_end = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int g[$];
        int gp[$];
        int p1_cnt;

        rst = 1'b1;
        s0_valid = 1'b0; s0_write = 1'b0; s0_addr = '0; s0_wdata = '0;
        s1_valid = 1'b0; s1_write = 1'b0; s1_addr = '0; s1_wdata = '0;
        pwm_period_end = 1'b0;
        for (int a = 0; a < 5; a++) mdl[a] = 8'h00;

        vecs[0]  = '{0, 1, 7'h01, 8'hA5, 8'hA5, 0};
        vecs[1]  = '{0, 0, 7'h01, 8'h00, 8'hA5, 0};
        vecs[2]  = '{1, 1, 7'h00, 8'h3C, 8'h3C, 0};
        vecs[3]  = '{1, 0, 7'h00, 8'h00, 8'h3C, 0};
        vecs[4]  = '{0, 1, 7'h02, 8'h5A, 8'h5A, 0};
        vecs[5]  = '{1, 1, 7'h03, 8'hC3, 8'hC3, 0};
        vecs[6]  = '{0, 0, 7'h03, 8'h00, 8'hC3, 0};
        vecs[7]  = '{1, 0, 7'h02, 8'h00, 8'h5A, 0};
        vecs[8]  = '{1, 1, 7'h05, 8'hFF, 8'h00, 1};
        vecs[9]  = '{1, 0, 7'h05, 8'h00, 8'h00, 1};
        vecs[10] = '{0, 1, 7'h7F, 8'h11, 8'h00, 1};
        vecs[11] = '{0, 0, 7'h04, 8'h00, 8'h00, 0};
        vecs[12] = '{0, 1, 7'h00, 8'hFF, 8'hFF, 0};
        vecs[13] = '{1, 0, 7'h01, 8'h00, 8'hA5, 0};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset();
        chk("rst_s0_ready_idle", {31'd0, s0_ready}, 32'd0);

        for (int i = 0; i < 14; i++) apply_vec(vecs[i]);

        // Reset during EXEC of a read: request dropped, no response
        drive_req(1'b0, 1'b0, 7'h01, 8'h00, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int a = 0; a < 5; a++) mdl[a] = 8'h00;
        @(negedge clk);
        check_reset();
        apply_vec('{0, 1, 7'h01, 8'hA5, 8'hA5, 0});
        apply_vec('{0, 0, 7'h01, 8'h00, 8'hA5, 0});

        // Both ports requesting continuously
        reset_both();
        @(posedge clk); #1;
        s0_valid = 1'b1; s0_write = 1'b1; s0_addr = 7'h00; s0_wdata = 8'h11;
        s1_valid = 1'b1; s1_write = 1'b1; s1_addr = 7'h00; s1_wdata = 8'h22;
        p1_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (s0_ready) g.push_back(0);
            else if (s1_ready) g.push_back(1);
            if (p_s0_ready) gp.push_back(0);
            if (p_s1_ready) p1_cnt++;
        end
        @(posedge clk); #1;
        s0_valid = 1'b0; s1_valid = 1'b0;
        @(negedge clk);
        chk("rr_grant_count", g.size(), 32'd6);
        for (int i = 0; i < g.size(); i++) chk($sformatf("rr_grant%0d", i), g[i], i % 2);
        chk("rr_last_data", {24'd0, en_reg_out_7_0}, 32'h22);
        chk("prio_s0_grants", gp.size(), 32'd6);
        chk("prio_s1_grants", p1_cnt, 32'd0);
        chk("prio_last_data", {24'd0, p_out_lo}, 32'h11);
        reset_both();

        // Deferred duty cycle
        pulse_pwm();
        chk("pwm_no_pending_duty", {24'd0, pwm_duty_cycle}, 32'd0);
        chk("pwm_no_pending_flag", {31'd0, duty_pending}, 32'd0);
        drive_req(1'b0, 1'b1, 7'h04, 8'h80, 1'b0);
        @(negedge clk);
        chk("duty_pend_exec", {31'd0, duty_pending}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("duty_pending_set", {31'd0, duty_pending}, 32'd1);
        chk("duty_held", {24'd0, pwm_duty_cycle}, 32'd0);
        chk("duty_imm_p", {24'd0, p_duty}, 32'h80);
        chk("duty_imm_p_pending", {31'd0, p_duty_pending}, 32'd0);
        repeat (3) @(negedge clk);
        chk("duty_still_held", {24'd0, pwm_duty_cycle}, 32'd0);
        pulse_pwm();
        chk("duty_applied", {24'd0, pwm_duty_cycle}, 32'h80);
        chk("duty_pending_clr", {31'd0, duty_pending}, 32'd0);
        mdl[4] = 8'h80;
        apply_vec('{1, 0, 7'h04, 8'h00, 8'h80, 0});

        drive_req(1'b1, 1'b1, 7'h04, 8'h55, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("duty2_pending", {31'd0, duty_pending}, 32'd1);
        chk("duty2_held", {24'd0, pwm_duty_cycle}, 32'h80);
        drive_req(1'b0, 1'b1, 7'h04, 8'h40, 1'b1);
        @(negedge clk);
        @(posedge clk); #1 pwm_period_end = 1'b0;
        @(negedge clk);
        chk("duty_coincident", {24'd0, pwm_duty_cycle}, 32'h40);
        chk("duty_coincident_pend", {31'd0, duty_pending}, 32'd0);
        mdl[4] = 8'h40;
        pulse_pwm();
        chk("duty_no_reapply", {24'd0, pwm_duty_cycle}, 32'h40);
        apply_vec('{0, 0, 7'h04, 8'h00, 8'h40, 0});

        repeat (3) @(negedge clk);
        chk("sb_drain", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
